// File: rtl/aes_inv_key_schedule_128_pkg.sv
// aes_inv_key_schedule_128_pkg: shared AES widths, FSM encoding, Rcon/S-box tables and word helpers.
package aes_inv_key_schedule_128_pkg;
  localparam int KEY_W = 128;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [KEY_W-1:0] key_t;
  typedef enum logic [1:0] {IDLE, FWD, OUT} state_e;
  localparam logic [0:9][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction
  function automatic word_t sub_word(input word_t w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction
  function automatic word_t rcon(input logic [3:0] n);
    return (n >= 4'd1 && n <= 4'd10) ? {RCON[n - 4'd1], 24'h0} : '0;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_inv_key_schedule_128_inv_mix_word.sv
// aes_inv_key_schedule_128_inv_mix_word: combinational InvMixColumns on one 32-bit column, byte 0 in [31:24].
module aes_inv_key_schedule_128_inv_mix_word
  import aes_inv_key_schedule_128_pkg::*;
(
  input  word_t w,
  output word_t y
);
  logic [3:0][7:0] a, x2, x4, x8, m9, mb, md, me;
  always_comb begin
    a = w;
    for (int j = 0; j < 4; j++) begin
      x2[j] = xtime(a[j]);
      x4[j] = xtime(x2[j]);
      x8[j] = xtime(x4[j]);
      m9[j] = x8[j] ^ a[j];
      mb[j] = x8[j] ^ x2[j] ^ a[j];
      md[j] = x8[j] ^ x4[j] ^ a[j];
      me[j] = x8[j] ^ x4[j] ^ x2[j];
    end
    y = {me[3] ^ mb[2] ^ md[1] ^ m9[0], m9[3] ^ me[2] ^ mb[1] ^ md[0],
         md[3] ^ m9[2] ^ me[1] ^ mb[0], mb[3] ^ md[2] ^ m9[1] ^ me[0]};
  end
endmodule

// File: rtl/aes_inv_key_schedule_128.sv
// aes_inv_key_schedule_128: on-the-fly AES-128 key schedule that runs forward to round 10,
// then streams round keys 10..0 by undoing one round step per accepted key.
module aes_inv_key_schedule_128
  import aes_inv_key_schedule_128_pkg::*;
#(
  parameter bit EQ_INV_KEYS = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_round,
  output logic         rk_last
);
  state_e state;
  key_t key, fwd_key, inv_key, out_key;
  logic [3:0] r;
  word_t k0, k1, k2, k3, t, n0, n1, n2, i3;
  assign {k0, k1, k2, k3} = key;
  assign i3 = k3 ^ k2;
  // One SubWord/Rcon serves both directions: forward uses k3 and Rcon(r+1), inverse uses k3' and Rcon(r).
  assign t = sub_word(rot_word(state == FWD ? k3 : i3)) ^ rcon(state == FWD ? r + 4'd1 : r);
  assign n0 = k0 ^ t;
  assign n1 = k1 ^ n0;
  assign n2 = k2 ^ n1;
  assign fwd_key = {n0, n1, n2, k3 ^ n2};
  assign inv_key = {n0, k1 ^ k0, k2 ^ k1, i3};
  if (EQ_INV_KEYS) begin : g_eq
    key_t m;
    for (genvar i = 0; i < 4; i++) begin : g_col
      aes_inv_key_schedule_128_inv_mix_word u_imc (.w(key[32*i +: 32]), .y(m[32*i +: 32]));
    end
    assign out_key = (r != 4'd0 && r != 4'd10) ? m : key;
  end else begin : g_plain
    assign out_key = key;
  end
  assign busy = state != IDLE;
  assign rk_valid = state == OUT;
  assign rk_round = rk_valid ? r : 4'd0;
  assign rk_last = rk_valid && r == 4'd0;
  assign rk_data = rk_valid ? out_key : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      key <= '0;
      r <= '0;
    end else if (abort) begin
      state <= IDLE;
      r <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          key <= key_in;
          r <= '0;
          state <= FWD;
        end
        FWD: if (r == 4'd10) state <= OUT;
        else begin
          key <= fwd_key;
          r <= r + 4'd1;
        end
        OUT: if (rk_ready) begin
          if (r == 4'd0) state <= IDLE;
          else begin
            key <= inv_key;
            r <= r - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_key_schedule_128.sv
// tb_aes_inv_key_schedule_128: scoreboard bench driving a plain and an equivalent-inverse instance in lockstep.
module tb_aes_inv_key_schedule_128;
  localparam logic [127:0] K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  typedef struct {logic [3:0] rnd; logic last; logic [127:0] d0; logic [127:0] d1;} exp_t;
  logic clk = 1'b0;
  logic rst_n, start, abort, rk_ready, rand_ready;
  logic [127:0] key_in;
  logic busy0, v0, l0, busy1, v1, l1;
  logic [127:0] d0, d1;
  logic [3:0] rnd0, rnd1;
  logic [127:0] fk [0:10];
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  aes_inv_key_schedule_128 #(.EQ_INV_KEYS(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key_in(key_in), .busy(busy0),
    .rk_valid(v0), .rk_ready(rk_ready), .rk_data(d0), .rk_round(rnd0), .rk_last(l0));
  aes_inv_key_schedule_128 #(.EQ_INV_KEYS(1'b1)) dut_eq (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key_in(key_in), .busy(busy1),
    .rk_valid(v1), .rk_ready(rk_ready), .rk_data(d1), .rk_round(rnd1), .rk_last(l1));
  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [31:0] imc_w(input logic [31:0] w);
    logic [7:0] c0, c1, c2, c3;
    {c0, c1, c2, c3} = w;
    return {gm(c0, 14) ^ gm(c1, 11) ^ gm(c2, 13) ^ gm(c3, 9), gm(c0, 9) ^ gm(c1, 14) ^ gm(c2, 11) ^ gm(c3, 13),
            gm(c0, 13) ^ gm(c1, 9) ^ gm(c2, 14) ^ gm(c3, 11), gm(c0, 11) ^ gm(c1, 13) ^ gm(c2, 9) ^ gm(c3, 14)};
  endfunction
  function automatic logic [127:0] imc_key(input logic [127:0] k);
    return {imc_w(k[127:96]), imc_w(k[95:64]), imc_w(k[63:32]), imc_w(k[31:0])};
  endfunction
  task automatic push_sched();
    for (int r = 10; r >= 0; r--)
      q.push_back('{4'(r), r == 0, fk[r], (r == 0 || r == 10) ? fk[r] : imc_key(fk[r])});
  endtask
  task automatic do_start(input logic [127:0] k);
    start = 1'b1;
    key_in = k;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_valid(input int n0);
    int n = n0;
    while (!v0 && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", 136'(n), 136'd11);
  endtask
  task automatic drain();
    int n = 0;
    while (v0 && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    chk("drained", {v0, v1, 1'b0, q.size() == 0}, {3'b000, 1'b1});
  endtask
  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end
  initial begin
    exp_t e;
    logic pv = 1'b0, pr = 1'b0;
    logic [263:0] ps = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || abort) pv = 1'b0;
      else begin
        if (pv && !pr) chk("stall_stable", 136'({v0, v1, rnd0, rnd1, l0, l1, d0 ^ d1}), 136'(ps));
        if (v0 && rk_ready) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_key: got round %0d, expected no output", rnd0);
          end else begin
            e = q.pop_front();
            chk("round", {rnd0, rnd1, l0, l1, v1, busy0, busy1}, {e.rnd, e.rnd, e.last, e.last, 3'b111});
            chk("data", d0, e.d0);
            chk("data_eq", d1, e.d1);
          end
        end
        pv = v0;
        pr = rk_ready;
        ps = 264'({v0, v1, rnd0, rnd1, l0, l1, d0 ^ d1});
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    fk[0] = K;
    fk[1] = 128'ha0fafe1788542cb123a339392a6c7605;
    fk[2] = 128'hf2c295f27a96b9435935807a7359f67f;
    fk[3] = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fk[4] = 128'hef44a541a8525b7fb671253bdb0bad00;
    fk[5] = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fk[6] = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fk[7] = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fk[8] = 128'head27321b58dbad2312bf5607f8d292f;
    fk[9] = 128'hac7766f319fadc2128d12941575c006e;
    fk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    rst_n = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    rand_ready = 1'b0;
    key_in = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("reset", {busy0, v0, rnd0, l0, d0 | d1, busy1, v1, l1}, '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 push_sched();
    do_start(K);
    wait_valid(0);
    begin
      int cnt = 1;
      while (cnt < 30) begin
        @(posedge clk);
        #1 if (!v0) break;
        cnt++;
      end
      chk("back_to_back", 136'(cnt), 136'd11);
      chk("sched_done", {busy0, 1'b0, q.size() == 0}, {2'b00, 1'b1});
    end
    rand_ready = 1'b1;
    push_sched();
    do_start(K);
    wait_valid(0);
    drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1 push_sched();
    do_start(K);
    @(posedge clk);
    #1 start = 1'b1;
    key_in = '0;
    @(posedge clk);
    #1 start = 1'b0;
    key_in = K;
    wait_valid(2);
    begin
      int n = 0;
      while (!(v0 && rnd0 == 4'd0) && n < 40) begin
        @(posedge clk);
        #1 n++;
      end
    end
    start = 1'b1;
    key_in = '0;
    @(posedge clk);
    #1 chk("idle_after_last", {v0, busy0, v1, busy1}, '0);
    push_sched();
    key_in = K;
    @(posedge clk);
    #1 start = 1'b0;
    wait_valid(0);
    drain();
    push_sched();
    do_start(K);
    repeat (4) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_fwd", {v0, busy0, v1, busy1}, '0);
    q.delete();
    repeat (15) @(posedge clk);
    #1 push_sched();
    do_start(K);
    wait_valid(0);
    begin
      int n = 0;
      while (rnd0 != 4'd6 && n < 40) begin
        @(posedge clk);
        #1 n++;
      end
    end
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    start = 1'b0;
    chk("abort_out", {v0, busy0, v1, busy1}, '0);
    q.delete();
    repeat (15) @(posedge clk);
    #1 push_sched();
    do_start(K);
    wait_valid(0);
    drain();
    push_sched();
    do_start(K);
    wait_valid(0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_out", {busy0, v0, rnd0, l0, d0 | d1, busy1, v1, l1}, '0);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_sched();
    do_start(K);
    wait_valid(0);
    drain();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
